// File: rtl/mem_arbiter_if.sv
// Two-requester memory arbiter bus: requester ports, shared read data,
// single-port memory side and status.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // requester side
  logic          req0, req1;
  logic          we0, we1;
  logic          lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  // memory side
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // status
  logic          busy, owner;

  // arbiter view
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1,
    input  addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  // requesters plus memory model view
  modport master (
    output req0, req1, we0, we1, lock0, lock1,
    output addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter. Ownership alternates on ties, a locked owner
// may keep the memory for up to BURST_MAX back-to-back beats, and read
// data returns one cycle after the grant.
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(BURST_MAX) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_MAX - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic          last_owner;

  logic own_req, own_lock, oth_req, rel;

  // Current owner's view of the request lines and the release decision.
  // While owning, gnt equals req, so a missing req is the only way a
  // cycle passes without a beat.
  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    oth_req  = 1'b0;
    case (state)
      OWN0: begin own_req = bus.req0; own_lock = bus.lock0; oth_req = bus.req1; end
      OWN1: begin own_req = bus.req1; own_lock = bus.lock1; oth_req = bus.req0; end
      default: ;
    endcase
    rel = !own_req || !own_lock || (beat_cnt == LAST_BEAT);
  end

  // Grant and memory-side mux, all decoded from the state register.
  always_comb begin
    bus.gnt0      = (state == OWN0) && bus.req0;
    bus.gnt1      = (state == OWN1) && bus.req1;
    bus.mem_en    = bus.gnt0 || bus.gnt1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      OWN0: begin bus.mem_we = bus.we0; bus.mem_addr = bus.addr0; bus.mem_wdata = bus.wdata0; end
      OWN1: begin bus.mem_we = bus.we1; bus.mem_addr = bus.addr1; bus.mem_wdata = bus.wdata1; end
      default: ;
    endcase
    bus.busy  = (state != IDLE);
    bus.owner = (state == OWN1);
    bus.rdata = bus.mem_rdata;
  end

  // Ownership FSM: tie-break against the last owner, burst counting, and
  // hand-over straight to the next owner without an idle cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_owner <= 1'b1;  // port 0 wins the first tie
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (bus.req0 && bus.req1) state <= last_owner ? OWN0 : OWN1;
          else if (bus.req0)        state <= OWN0;
          else if (bus.req1)        state <= OWN1;
        end
        OWN0, OWN1: begin
          if (rel) begin
            beat_cnt   <= '0;
            last_owner <= (state == OWN1);
            if (oth_req)      state <= (state == OWN0) ? OWN1 : OWN0;
            else if (own_req) state <= state;  // re-entry, fresh burst
            else              state <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data valid one cycle after a read grant; reset drops it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
    end else begin
      bus.rvalid0 <= bus.gnt0 && !bus.we0;
      bus.rvalid1 <= bus.gnt1 && !bus.we1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for the tie,
// single read and write cases, then hand sequences for burst cap, early
// unlock and reset during a read.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus();

  mem_arbiter #(.AW(32), .DW(32), .BURST_MAX(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] rd_val = 32'hC0DE0000;

  typedef struct {
    logic r0, r1, w0, w1, l0, l1;
    logic g0, g1, v0, v1, bsy, own, mwe;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, r1, w0, w1, l0, l1);
    bus.req0   = r0;  bus.req1  = r1;
    bus.we0    = w0;  bus.we1   = w1;
    bus.lock0  = l0;  bus.lock1 = l1;
    bus.addr0  = 32'h10;
    bus.addr1  = 32'h20;
    bus.wdata0 = 32'h11111111;
    bus.wdata1 = 32'hDEADBEEF;
    rd_val     = rd_val + 32'h1;
    bus.mem_rdata = rd_val;
  endtask

  // apply one cycle's inputs at the falling edge, settle, return
  task automatic cyc(input logic r0, r1, w0, w1, l0, l1);
    @(negedge clk);
    drive(r0, r1, w0, w1, l0, l1);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    //            r0 r1 w0 w1 l0 l1  g0 g1 v0 v1 bsy own mwe
    tv[0]  = '{1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};  // tie seen in IDLE
    tv[1]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0};  // port 0 wins first tie
    tv[2]  = '{1, 1, 0, 0, 0, 0,  0, 1, 1, 0, 1, 1, 0};  // alternate to port 1
    tv[3]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0, 1, 1, 0, 0};  // back to port 0
    tv[4]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 1, 0};  // OWN1, no req
    tv[5]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};  // single read requested
    tv[6]  = '{1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0};  // read granted
    tv[7]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0};  // rvalid0
    tv[8]  = '{0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0};  // write requested
    tv[9]  = '{0, 1, 0, 1, 0, 0,  0, 1, 0, 0, 1, 1, 1};  // write granted
    tv[10] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0};  // no rvalid for write
    tv[11] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};  // idle

    // reset state with a request pending
    reset = 1'b0;
    drive(1, 1, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cyc(tv[i].r0, tv[i].r1, tv[i].w0, tv[i].w1, tv[i].l0, tv[i].l1);
      chk($sformatf("v%0d_gnt0", i), bus.gnt0, tv[i].g0);
      chk($sformatf("v%0d_gnt1", i), bus.gnt1, tv[i].g1);
      chk($sformatf("v%0d_rvalid0", i), bus.rvalid0, tv[i].v0);
      chk($sformatf("v%0d_rvalid1", i), bus.rvalid1, tv[i].v1);
      chk($sformatf("v%0d_busy", i), bus.busy, tv[i].bsy);
      chk($sformatf("v%0d_owner", i), bus.owner, tv[i].own);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we, tv[i].mwe);
      chk($sformatf("v%0d_mem_en", i), bus.mem_en, tv[i].g0 | tv[i].g1);
      if (tv[i].g0) chk($sformatf("v%0d_addr0", i), bus.mem_addr, 32'h10);
      if (tv[i].g1) begin
        chk($sformatf("v%0d_addr1", i), bus.mem_addr, 32'h20);
        chk($sformatf("v%0d_wdata1", i), bus.mem_wdata, 32'hDEADBEEF);
      end
      if (tv[i].v0 | tv[i].v1) chk($sformatf("v%0d_rdata", i), bus.rdata, rd_val);
    end

    // burst cap: four locked beats for port 1, then port 0
    do_reset();
    cyc(0, 1, 0, 0, 0, 1);
    chk("burst_idle", bus.gnt1, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 0, 0, 1);
      chk($sformatf("burst_gnt1_b%0d", k), {bus.gnt0, bus.gnt1}, 2'b01);
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("burst_handover_gnt0", {bus.gnt0, bus.gnt1}, 2'b10);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // early unlock: re-entry restarts the burst count with no idle gap
    do_reset();
    cyc(1, 0, 0, 0, 1, 0);
    chk("unlock_idle", bus.gnt0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("unlock_b0", bus.gnt0, 1);
    cyc(1, 0, 0, 0, 1, 0);
    chk("unlock_b1", bus.gnt0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("unlock_b2", bus.gnt0, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 0, 0, 1, 0);
      chk($sformatf("reentry_b%0d", k), {bus.gnt0, bus.gnt1, bus.busy}, 3'b101);
    end
    cyc(0, 1, 0, 0, 0, 0);
    chk("reentry_handover_gnt1", {bus.gnt0, bus.gnt1}, 2'b01);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // reset while a read grant is on the bus
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    chk("midrd_idle", bus.gnt0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("midrd_gnt0", bus.gnt0, 1);
    #1 reset = 1'b0;
    #1;
    chk("midrd_async_gnt0", bus.gnt0, 0);
    chk("midrd_async_mem_en", bus.mem_en, 0);
    chk("midrd_async_busy", bus.busy, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk($sformatf("midrd_hold_%0d", k), {bus.gnt0, bus.rvalid0, bus.busy}, 3'b000);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk($sformatf("midrd_no_rvalid_%0d", k), bus.rvalid0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
